snoop_msi_array: RTL and testbench
==================================

# snoop_msi_array

- Parametrised snooping MSI coherence controller for a direct-mapped private cache of `LINES` lines; tracks per-line state and tag.
- Two request paths:
  - Bus snoops: answers them with write-back / abort indications.
  - Local CPU requests: turns them into bus transactions and, when a dirty line is evicted, a victim write-back.
- Sits between the cache data array and the shared snooping bus; replaces the single-line bus-side state machine.

## Interface
Parameters:
- `ADDR_W`, 8 — block address width in bits.
- `LINES`, 4 — number of cache lines; power of two, ≥ 2; `IDX_W = log2(LINES)`.

Ports:
- `clock`  in  1  — sole clock, rising edge.
- `reset`  in  1  — synchronous, active-high.
- `bus_valid`  in  1  — snooped bus transaction present this cycle.
- `bus_op`  in  2  — snooped op: `00` read_miss, `01` write_miss, `10` invalidate, `11` no-op.
- `bus_addr`  in  ADDR_W  — snooped block address.
- `cpu_valid`  in  1  — CPU access request.
- `cpu_write`  in  1  — 1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  — CPU block address.
- `cpu_ready`  out  1  — combinational; CPU request accepted this cycle.
- `cpu_hit`  out  1  — registered; accepted CPU access hit.
- `req_valid`  out  1  — registered; controller issues a bus transaction.
- `req_op`  out  2  — registered; same encoding as `bus_op`.
- `req_addr`  out  ADDR_W  — registered; address of the issued transaction.
- `snoop_wb`  out  1  — registered; write back the snooped block and abort the memory access.
- `victim_wb`  out  1  — registered; write back the evicted dirty victim.
- `victim_addr`  out  ADDR_W  — registered; `{old_tag, index}` of the victim.
- `protocol_err`  out  1  — registered; invalidate snooped on an exclusive line.

## Operation
- Line state encoding: `00` invalid, `01` exclusive (modified), `10` shared.
- Address split:
  - index = `addr[IDX_W-1:0]`
  - tag = `addr[ADDR_W-1:IDX_W]`
  - Hit = tag equal AND state ≠ invalid.
- Snoop path (`bus_valid`, hit only; a miss or no-op changes nothing and all flags stay 0):
  - exclusive + read_miss → shared, `snoop_wb`=1.
  - exclusive + write_miss → invalid, `snoop_wb`=1.
  - exclusive + invalidate → invalid, `protocol_err`=1, `snoop_wb`=0.
  - shared + read_miss → shared, no flags.
  - shared + write_miss → invalid.
  - shared + invalidate → invalid.
- CPU path (`cpu_valid && cpu_ready`):
  - Read hit: `cpu_hit`=1, no state change, no bus request.
  - Write hit on exclusive: `cpu_hit`=1, no request.
  - Write hit on shared: → exclusive, `cpu_hit`=1, `req_op`=invalidate.
  - Read miss: load tag, → shared, `req_op`=read_miss.
  - Write miss: load tag, → exclusive, `req_op`=write_miss.
  - Any miss whose old line is exclusive: `victim_wb`=1, `victim_addr` = old `{tag, index}`.
- Arbitration:
  - `cpu_ready` = !(`bus_valid` && `bus_op`≠`11` && bus index == cpu index).
  - Same-index snoop always wins; the CPU holds its request until ready.
  - Different indices are processed in the same cycle.

## Timing
- All state and registered outputs update on the rising `clock` edge; latency from request to flag is 1 cycle.
- Flags are single-cycle pulses: `req_valid`, `cpu_hit`, `snoop_wb`, `victim_wb`, `protocol_err`.
- `req_op`, `req_addr`, `victim_addr` are valid only while their strobe is high, else 0.
- Reset, including mid-operation: all lines invalid, all tags 0, every registered output 0, counters 0. `cpu_ready` follows its equation, with no reset gating.
- Back-to-back requests to the same line see the state written in the previous cycle.

## Configuration
- `SNOOP_STATS_EN` defined adds three outputs:
  - `stat_snoop_wb`, 16 bits, counts `snoop_wb` pulses.
  - `stat_victim_wb`, 16 bits, counts `victim_wb` pulses.
  - `stat_inval`, 16 bits, counts snoop transitions to invalid.
  - All saturate at `16'hFFFF` and clear on `reset`.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, then CPU read `8'h05` → next cycle `req_valid`=1, `req_op`=00, `req_addr`=`8'h05`, line 1 shared; repeating the read → `cpu_hit`=1, `req_valid`=0.
- CPU write `8'h05` while shared → `req_op`=10, line exclusive; then snoop read_miss `8'h05` → `snoop_wb`=1, line shared.
- Line 1 exclusive with tag of `8'h05`; CPU write `8'h09` → `req_op`=01, `victim_wb`=1, `victim_addr`=`8'h05`.
- Snoop invalidate `8'h09` while that line is exclusive → `protocol_err`=1, line invalid, `snoop_wb`=0.
- Same cycle: snoop write_miss `8'h0D` and CPU read `8'h01` (same index 1) → `cpu_ready`=0. Same cycle: snoop on `8'h02` and CPU read `8'h03` (different index) → `cpu_ready`=1, both processed.
- `SNOOP_STATS_EN`: 3 snoop write-backs then `reset` asserted mid-stream → `stat_snoop_wb`=3, then 0 after reset, all lines invalid.

Source files
------------

// File: rtl/snoop_msi_if.sv
// Snoop bus / CPU request bundle for the MSI line-array controller.
// master: environment side (drives snoops and CPU requests).
// slave : controller side (answers with flags and bus requests).
interface snoop_msi_if #(
    parameter int ADDR_W = 8
);
    logic              bus_valid;
    logic [1:0]        bus_op;
    logic [ADDR_W-1:0] bus_addr;
    logic              cpu_valid;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ready;
    logic              cpu_hit;
    logic              req_valid;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              snoop_wb;
    logic              victim_wb;
    logic [ADDR_W-1:0] victim_addr;
    logic              protocol_err;

    modport master (
        output bus_valid, bus_op, bus_addr, cpu_valid, cpu_write, cpu_addr,
        input  cpu_ready, cpu_hit, req_valid, req_op, req_addr,
               snoop_wb, victim_wb, victim_addr, protocol_err
    );

    modport slave (
        input  bus_valid, bus_op, bus_addr, cpu_valid, cpu_write, cpu_addr,
        output cpu_ready, cpu_hit, req_valid, req_op, req_addr,
               snoop_wb, victim_wb, victim_addr, protocol_err
    );
endinterface

// File: rtl/snoop_msi_array.sv
// Snooping MSI controller for a direct-mapped cache of LINES lines.
// Holds per-line state and tag, answers bus snoops and turns CPU
// accesses into bus transactions / victim write-backs.
// Optional build macro SNOOP_STATS_EN adds saturating event counters.
module snoop_msi_array #(
    parameter int ADDR_W = 8,
    parameter int LINES  = 4
) (
    input  logic        clock,
    input  logic        reset,
    snoop_msi_if.slave  bus
`ifdef SNOOP_STATS_EN
    ,
    output logic [15:0] stat_snoop_wb,
    output logic [15:0] stat_victim_wb,
    output logic [15:0] stat_inval
`endif
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    localparam logic [1:0] ST_INV = 2'b00;
    localparam logic [1:0] ST_EXC = 2'b01;
    localparam logic [1:0] ST_SHR = 2'b10;

    localparam logic [1:0] OP_RDM = 2'b00;
    localparam logic [1:0] OP_WRM = 2'b01;
    localparam logic [1:0] OP_INV = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    logic [1:0]       st [LINES];
    logic [TAG_W-1:0] tg [LINES];

    logic              cpu_hit_q, req_valid_q, snoop_wb_q, victim_wb_q, perr_q;
    logic [1:0]        req_op_q;
    logic [ADDR_W-1:0] req_addr_q, victim_addr_q;

    logic [IDX_W-1:0] b_idx, c_idx;
    logic [TAG_W-1:0] b_tag, c_tag;
    logic             b_act, b_hit, c_go, c_hit;
    logic [1:0]       b_st, c_st;

    assign b_idx = bus.bus_addr[IDX_W-1:0];
    assign b_tag = bus.bus_addr[ADDR_W-1:IDX_W];
    assign c_idx = bus.cpu_addr[IDX_W-1:0];
    assign c_tag = bus.cpu_addr[ADDR_W-1:IDX_W];
    assign b_st  = st[b_idx];
    assign c_st  = st[c_idx];

    // A live snoop on the CPU's index blocks the CPU, hit or not.
    assign b_act = bus.bus_valid && (bus.bus_op != OP_NOP);
    assign b_hit = b_act && (b_st != ST_INV) && (tg[b_idx] == b_tag);
    assign c_hit = (c_st != ST_INV) && (tg[c_idx] == c_tag);
    assign bus.cpu_ready = !(b_act && (b_idx == c_idx));
    assign c_go  = bus.cpu_valid && bus.cpu_ready;

    assign bus.cpu_hit      = cpu_hit_q;
    assign bus.req_valid    = req_valid_q;
    assign bus.req_op       = req_op_q;
    assign bus.req_addr     = req_addr_q;
    assign bus.snoop_wb     = snoop_wb_q;
    assign bus.victim_wb    = victim_wb_q;
    assign bus.victim_addr  = victim_addr_q;
    assign bus.protocol_err = perr_q;

    // Line array update plus single-cycle response flags. Snoop and CPU
    // only act together on different indices, so their writes never collide.
    always_ff @(posedge clock) begin
        cpu_hit_q     <= 1'b0;
        req_valid_q   <= 1'b0;
        req_op_q      <= 2'b00;
        req_addr_q    <= '0;
        snoop_wb_q    <= 1'b0;
        victim_wb_q   <= 1'b0;
        victim_addr_q <= '0;
        perr_q        <= 1'b0;
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                st[i] <= ST_INV;
                tg[i] <= '0;
            end
        end else begin
            if (b_hit) begin
                case (b_st)
                    ST_EXC: begin
                        case (bus.bus_op)
                            OP_RDM: begin st[b_idx] <= ST_SHR; snoop_wb_q <= 1'b1; end
                            OP_WRM: begin st[b_idx] <= ST_INV; snoop_wb_q <= 1'b1; end
                            default: begin st[b_idx] <= ST_INV; perr_q <= 1'b1; end
                        endcase
                    end
                    default: begin
                        if (bus.bus_op != OP_RDM) st[b_idx] <= ST_INV;
                    end
                endcase
            end
            if (c_go) begin
                if (c_hit) begin
                    cpu_hit_q <= 1'b1;
                    if (bus.cpu_write && c_st == ST_SHR) begin
                        st[c_idx]   <= ST_EXC;
                        req_valid_q <= 1'b1;
                        req_op_q    <= OP_INV;
                        req_addr_q  <= bus.cpu_addr;
                    end
                end else begin
                    tg[c_idx]   <= c_tag;
                    st[c_idx]   <= bus.cpu_write ? ST_EXC : ST_SHR;
                    req_valid_q <= 1'b1;
                    req_op_q    <= bus.cpu_write ? OP_WRM : OP_RDM;
                    req_addr_q  <= bus.cpu_addr;
                    if (c_st == ST_EXC) begin
                        victim_wb_q   <= 1'b1;
                        victim_addr_q <= {tg[c_idx], c_idx};
                    end
                end
            end
        end
    end

`ifdef SNOOP_STATS_EN
    logic ev_swb, ev_vwb, ev_inv;
    assign ev_swb = b_hit && (b_st == ST_EXC) && (bus.bus_op != OP_INV);
    assign ev_vwb = c_go && !c_hit && (c_st == ST_EXC);
    assign ev_inv = b_hit && (bus.bus_op != OP_RDM);

    // Saturating counters, advanced on the same edge that raises each pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_snoop_wb  <= '0;
            stat_victim_wb <= '0;
            stat_inval     <= '0;
        end else begin
            if (ev_swb && stat_snoop_wb != 16'hFFFF) stat_snoop_wb <= stat_snoop_wb + 16'd1;
            if (ev_vwb && stat_victim_wb != 16'hFFFF) stat_victim_wb <= stat_victim_wb + 16'd1;
            if (ev_inv && stat_inval != 16'hFFFF) stat_inval <= stat_inval + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_snoop_msi_array.sv
// Bench for snoop_msi_array: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a line-table model.
module tb_snoop_msi_array;
    localparam int L = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    snoop_msi_if #(.ADDR_W(8)) bif ();

`ifdef SNOOP_STATS_EN
    logic [15:0] s_swb, s_vwb, s_inv;
`endif

    snoop_msi_array #(.ADDR_W(8), .LINES(L)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif.slave)
`ifdef SNOOP_STATS_EN
        ,
        .stat_snoop_wb  (s_swb),
        .stat_victim_wb (s_vwb),
        .stat_inval     (s_inv)
`endif
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: line state 0 invalid, 1 exclusive, 2 shared; addr = tag*L + idx.
    int   mst [L];
    int   mtag[L];
    bit   started = 1'b0;
    logic e_hit, e_rv, e_swb, e_vwb, e_perr;
    logic [1:0] e_op;
    logic [7:0] e_ra, e_va;
    int   e_s1 = 0, e_s2 = 0, e_s3 = 0;

    always @(posedge clock) begin
        int bi, bt, ci, ct;
        bit bact, bh, ch, rdy;
        started = 1'b1;
        e_hit = 0; e_rv = 0; e_swb = 0; e_vwb = 0; e_perr = 0;
        e_op = 0; e_ra = 0; e_va = 0;
        if (reset) begin
            for (int i = 0; i < L; i++) begin mst[i] = 0; mtag[i] = 0; end
            e_s1 = 0; e_s2 = 0; e_s3 = 0;
        end else begin
            bi = int'(bif.bus_addr) % L;  bt = int'(bif.bus_addr) / L;
            ci = int'(bif.cpu_addr) % L;  ct = int'(bif.cpu_addr) / L;
            bact = bif.bus_valid && bif.bus_op != 2'd3;
            rdy  = !(bact && bi == ci);
            bh   = bact && mst[bi] != 0 && mtag[bi] == bt;
            ch   = mst[ci] != 0 && mtag[ci] == ct;
            if (bh) begin
                if (mst[bi] == 1 && bif.bus_op != 2'd2) e_swb = 1;
                if (mst[bi] == 1 && bif.bus_op == 2'd2) e_perr = 1;
                if (bif.bus_op == 2'd0) mst[bi] = 2;
                else begin
                    mst[bi] = 0;
                    if (e_s3 < 65535) e_s3++;
                end
            end
            if (bif.cpu_valid && rdy) begin
                if (ch) begin
                    e_hit = 1;
                    if (bif.cpu_write && mst[ci] == 2) begin
                        mst[ci] = 1; e_rv = 1; e_op = 2'd2; e_ra = bif.cpu_addr;
                    end
                end else begin
                    if (mst[ci] == 1) begin e_vwb = 1; e_va = 8'(mtag[ci] * L + ci); end
                    mtag[ci] = ct;
                    mst[ci]  = bif.cpu_write ? 1 : 2;
                    e_rv = 1;
                    e_op = bif.cpu_write ? 2'd1 : 2'd0;
                    e_ra = bif.cpu_addr;
                end
            end
            if (e_swb && e_s1 < 65535) e_s1++;
            if (e_vwb && e_s2 < 65535) e_s2++;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (started) begin
            chk("m_cpu_ready", bif.cpu_ready, !(bif.bus_valid && bif.bus_op != 2'd3 &&
                (bif.bus_addr % L) == (bif.cpu_addr % L)));
            chk("m_cpu_hit", bif.cpu_hit, e_hit);
            chk("m_req_valid", bif.req_valid, e_rv);
            chk("m_req_op", bif.req_op, e_op);
            chk("m_req_addr", bif.req_addr, e_ra);
            chk("m_snoop_wb", bif.snoop_wb, e_swb);
            chk("m_victim_wb", bif.victim_wb, e_vwb);
            chk("m_victim_addr", bif.victim_addr, e_va);
            chk("m_protocol_err", bif.protocol_err, e_perr);
`ifdef SNOOP_STATS_EN
            chk("m_stat_snoop_wb", s_swb, e_s1);
            chk("m_stat_victim_wb", s_vwb, e_s2);
            chk("m_stat_inval", s_inv, e_s3);
`endif
        end
    end

    task automatic drv(input bit bv, input logic [1:0] bop, input logic [7:0] ba,
                       input bit cv, input bit cw, input logic [7:0] ca);
        bif.bus_valid = bv; bif.bus_op = bop; bif.bus_addr = ba;
        bif.cpu_valid = cv; bif.cpu_write = cw; bif.cpu_addr = ca;
    endtask

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    initial begin
        drv(0, 2'd3, 8'h00, 0, 0, 8'h00);
        reset = 1'b1;
        cyc; cyc;
        reset = 1'b0;
        chk("rst_req_valid", bif.req_valid, 0);
        chk("rst_snoop_wb", bif.snoop_wb, 0);
        chk("rst_victim_addr", bif.victim_addr, 0);

        drv(0, 2'd3, 8'h00, 1, 0, 8'h05); cyc;
        chk("rd05_req_valid", bif.req_valid, 1);
        chk("rd05_req_op", bif.req_op, 2'b00);
        chk("rd05_req_addr", bif.req_addr, 8'h05);
        chk("rd05_cpu_hit", bif.cpu_hit, 0);
        cyc;
        chk("rd05_again_hit", bif.cpu_hit, 1);
        chk("rd05_again_req", bif.req_valid, 0);

        drv(0, 2'd3, 8'h00, 1, 1, 8'h05); cyc;
        chk("wr05_sh_req_op", bif.req_op, 2'b10);
        chk("wr05_sh_hit", bif.cpu_hit, 1);
        drv(1, 2'd0, 8'h05, 0, 0, 8'h00); cyc;
        chk("snp_rm05_wb", bif.snoop_wb, 1);

        drv(0, 2'd3, 8'h00, 1, 1, 8'h05); cyc;
        chk("wr05_again_op", bif.req_op, 2'b10);
        drv(0, 2'd3, 8'h00, 1, 1, 8'h09); cyc;
        chk("wr09_req_op", bif.req_op, 2'b01);
        chk("wr09_req_addr", bif.req_addr, 8'h09);
        chk("wr09_victim_wb", bif.victim_wb, 1);
        chk("wr09_victim_addr", bif.victim_addr, 8'h05);

        drv(1, 2'd2, 8'h09, 0, 0, 8'h00); cyc;
        chk("inv09_perr", bif.protocol_err, 1);
        chk("inv09_snoop_wb", bif.snoop_wb, 0);
        drv(0, 2'd3, 8'h00, 1, 0, 8'h09); cyc;
        chk("rd09_after_inv_req", bif.req_valid, 1);
        chk("rd09_after_inv_vwb", bif.victim_wb, 0);

        drv(1, 2'd1, 8'h0D, 1, 0, 8'h01); #1;
        chk("same_idx_ready", bif.cpu_ready, 0);
        cyc;
        chk("same_idx_no_req", bif.req_valid, 0);
        chk("same_idx_no_hit", bif.cpu_hit, 0);

        drv(0, 2'd3, 8'h00, 1, 1, 8'h02); cyc;
        drv(1, 2'd0, 8'h02, 1, 0, 8'h03); #1;
        chk("diff_idx_ready", bif.cpu_ready, 1);
        cyc;
        chk("diff_idx_snoop_wb", bif.snoop_wb, 1);
        chk("diff_idx_req_addr", bif.req_addr, 8'h03);

        // Three snoop write-backs, then reset mid-stream.
        drv(0, 2'd3, 8'h00, 0, 0, 8'h00);
        reset = 1'b1; cyc; reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drv(0, 2'd3, 8'h00, 1, 1, 8'h10 + 8'(k)); cyc;
            drv(1, 2'd0, 8'h10 + 8'(k), 0, 0, 8'h00); cyc;
            chk("stats_seq_swb", bif.snoop_wb, 1);
        end
`ifdef SNOOP_STATS_EN
        chk("stat_swb_3", s_swb, 16'd3);
`endif
        drv(0, 2'd3, 8'h00, 1, 1, 8'h20);
        reset = 1'b1; cyc; reset = 1'b0;
        drv(0, 2'd3, 8'h00, 0, 0, 8'h00);
`ifdef SNOOP_STATS_EN
        chk("stat_swb_rst", s_swb, 16'd0);
`endif
        chk("rst_mid_req", bif.req_valid, 0);
        drv(0, 2'd3, 8'h00, 1, 0, 8'h10); cyc;
        chk("post_rst_miss", bif.req_valid, 1);
        chk("post_rst_no_victim", bif.victim_wb, 0);

        // Random traffic over a small address pool so hits are frequent.
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            drv($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)),
                $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 15)));
            cyc;
        end
        reset = 1'b0;
        drv(0, 2'd3, 8'h00, 0, 0, 8'h00);
        cyc; cyc;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
